// File: rtl/bus_bridge_if.sv
// CPU-side memory bus between the core's memory stage and the bridge.
// The CPU drives address and write controls and receives read data.
interface bus_bridge_if;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport master (output Bus_addr, output Bus_wen, output Bus_wdata, input Bus_rdata);
  modport slave  (input Bus_addr, input Bus_wen, input Bus_wdata, output Bus_rdata);
endinterface

// File: rtl/bus_bridge.sv
// CPU bus bridge: routes accesses to DRAM or to the DIG/LED/SW/TIMER peripherals
// and scans the eight-digit 7-segment display.
module bus_bridge #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic         cpu_clk,
  input  logic         cpu_rst,
  bus_bridge_if.slave  bus,
  output logic [13:0]  dram_addr,
  output logic         dram_wen,
  output logic [31:0]  dram_wdata,
  input  logic [31:0]  dram_rdata,
  input  logic [23:0]  sw,
  output logic [23:0]  led,
  output logic [7:0]   dig_en,
  output logic [7:0]   seg
);

  localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_DIG    = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_LED    = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW     = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_TMR    = 32'hFFFF_F080;
  localparam int          SCAN_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  logic              is_dram_s, is_dig_s, is_led_s, is_sw_s, is_tmr_s;
  logic [31:0]       dig_q, dig_d, timer_q, timer_d;
  logic [23:0]       led_q, led_d, sw_meta_q, sw_sync_q;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        dig_en_q, dig_en_d, seg_q, seg_d;

  assign is_dram_s  = (bus.Bus_addr < PERIPH_BASE);
  assign is_dig_s   = (bus.Bus_addr == ADDR_DIG);
  assign is_led_s   = (bus.Bus_addr == ADDR_LED);
  assign is_sw_s    = (bus.Bus_addr == ADDR_SW);
  assign is_tmr_s   = (bus.Bus_addr == ADDR_TMR);

  assign dram_addr  = bus.Bus_addr[15:2];
  assign dram_wdata = bus.Bus_wdata;
  assign dram_wen   = is_dram_s & bus.Bus_wen;
  assign led        = led_q;
  assign dig_en     = dig_en_q;
  assign seg        = seg_q;

  // Read-data mux
  always_comb begin
    bus.Bus_rdata = 32'h0;
    if (is_dram_s) begin
      bus.Bus_rdata = dram_rdata;
    end else if (is_dig_s) begin
      bus.Bus_rdata = dig_q;
    end else if (is_led_s) begin
      bus.Bus_rdata = {8'h00, led_q};
    end else if (is_sw_s) begin
      bus.Bus_rdata = {8'h00, sw_sync_q};
    end else if (is_tmr_s) begin
      bus.Bus_rdata = timer_q;
    end else begin
      bus.Bus_rdata = 32'h0;
    end
  end

  // Next-state for registers, timer and display scan
  always_comb begin
    dig_d    = dig_q;
    led_d    = led_q;
    timer_d  = timer_q + 32'd1;
    scan_d   = scan_q + {{(SCAN_W-1){1'b0}}, 1'b1};
    idx_d    = idx_q;
    if (bus.Bus_wen && is_dig_s) begin
      dig_d = bus.Bus_wdata;
    end else begin
      dig_d = dig_q;
    end
    if (bus.Bus_wen && is_led_s) begin
      led_d = bus.Bus_wdata[23:0];
    end else begin
      led_d = led_q;
    end
    // A software load wins over the free-running increment on the same edge
    if (bus.Bus_wen && is_tmr_s) begin
      timer_d = bus.Bus_wdata;
    end else begin
      timer_d = timer_q + 32'd1;
    end
    if (scan_q == SCAN_LAST) begin
      scan_d = {SCAN_W{1'b0}};
      idx_d  = idx_q + 3'd1;
    end else begin
      idx_d  = idx_q;
    end
    dig_en_d = ~(8'b0000_0001 << idx_q);
    seg_d    = hex7(dig_q[{idx_q, 2'b00} +: 4]);
  end

  // State registers
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      dig_q     <= 32'h0;
      led_q     <= 24'h0;
      timer_q   <= 32'h0;
      sw_meta_q <= 24'h0;
      sw_sync_q <= 24'h0;
      scan_q    <= {SCAN_W{1'b0}};
      idx_q     <= 3'd0;
      dig_en_q  <= 8'hFE;
      seg_q     <= 8'hC0;
    end else begin
      dig_q     <= dig_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      dig_en_q  <= dig_en_d;
      seg_q     <= seg_d;
    end
  end

endmodule

// File: tb/tb_bus_bridge.sv
// Randomized scoreboard bench for bus_bridge against a cycle-count based reference model.
module tb_bus_bridge;
  localparam int unsigned SDIV  = 4;
  localparam logic [31:0] A_DIG = 32'hFFFF_F000;
  localparam logic [31:0] A_LED = 32'hFFFF_F060;
  localparam logic [31:0] A_SW  = 32'hFFFF_F070;
  localparam logic [31:0] A_TMR = 32'hFFFF_F080;
  localparam logic [31:0] A_BAD = 32'hFFFF_F0F0;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [13:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata, dram_rdata;
  logic [23:0] sw, led, sw_cur;
  logic [7:0]  dig_en, seg;

  always #5 cpu_clk = ~cpu_clk;

  bus_bridge_if bif();

  bus_bridge #(.SCAN_DIV(SDIV)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bif),
    .dram_addr(dram_addr), .dram_wen(dram_wen), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata), .sw(sw), .led(led), .dig_en(dig_en), .seg(seg)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;
    logic        dram_wen;
    logic [13:0] dram_addr;
    logic [31:0] dram_wdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: edges since release, register contents, sampled switch history
  int unsigned m_k;
  logic [31:0] m_dig, m_timer;
  logic [23:0] m_led;
  logic [23:0] m_sw_hist[$];
  logic [7:0]  m_dig_en, m_seg;

  task automatic model_reset();
    m_k = 0; m_dig = 32'h0; m_timer = 32'h0; m_led = 24'h0;
    m_sw_hist.delete();
    m_dig_en = 8'hFE; m_seg = 8'hC0;
  endtask

  function automatic exp_t model_expect(input logic [31:0] a, input logic w,
                                        input logic [31:0] wd, input logic [31:0] dr);
    exp_t e;
    logic [23:0] sync;
    sync = (m_sw_hist.size() == 2) ? m_sw_hist[0] : 24'h0;
    if (a < 32'hFFFF_F000) e.rdata = dr;
    else if (a == A_DIG)   e.rdata = m_dig;
    else if (a == A_LED)   e.rdata = {8'h00, m_led};
    else if (a == A_SW)    e.rdata = {8'h00, sync};
    else if (a == A_TMR)   e.rdata = m_timer;
    else                   e.rdata = 32'h0;
    e.led        = m_led;
    e.dig_en     = m_dig_en;
    e.seg        = m_seg;
    e.dram_wen   = (a < 32'hFFFF_F000) ? w : 1'b0;
    e.dram_addr  = a[15:2];
    e.dram_wdata = wd;
    return e;
  endfunction

  task automatic model_edge(input logic [31:0] a, input logic w, input logic [31:0] wd,
                            input logic [23:0] s);
    int unsigned idx;
    logic [31:0] dig_old;
    idx      = (m_k / SDIV) % 8;
    dig_old  = m_dig;
    m_dig_en = 8'hFF ^ (8'd1 << idx);
    m_seg    = hex_tab[(dig_old >> (4 * idx)) & 32'hF];
    if (w && a == A_DIG) m_dig = wd;
    if (w && a == A_LED) m_led = wd[23:0];
    if (w && a == A_TMR) m_timer = wd;
    else                 m_timer = m_timer + 32'd1;
    m_sw_hist.push_back(s);
    if (m_sw_hist.size() > 2) void'(m_sw_hist.pop_front());
    m_k = m_k + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation
  initial begin
    forever begin
      @(negedge cpu_clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("rdata",      bif.Bus_rdata,       mon_e.rdata);
        chk("led",        {8'h0, led},         {8'h0, mon_e.led});
        chk("dig_en",     {24'h0, dig_en},     {24'h0, mon_e.dig_en});
        chk("seg",        {24'h0, seg},        {24'h0, mon_e.seg});
        chk("dram_wen",   {31'h0, dram_wen},   {31'h0, mon_e.dram_wen});
        chk("dram_addr",  {18'h0, dram_addr},  {18'h0, mon_e.dram_addr});
        chk("dram_wdata", dram_wdata,          mon_e.dram_wdata);
      end
    end
  end

  task automatic cyc(input logic rst, input logic [31:0] a, input logic w,
                     input logic [31:0] wd, input logic [23:0] s);
    @(posedge cpu_clk);
    #2;
    cpu_rst       = rst;
    bif.Bus_addr  = a;
    bif.Bus_wen   = w;
    bif.Bus_wdata = wd;
    sw            = s;
    dram_rdata    = $urandom();
    if (!rst) model_reset();
    sb_q.push_back(model_expect(a, w, wd, dram_rdata));
    if (rst) model_edge(a, w, wd, s);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b1, a, 1'b0, $urandom(), sw_cur);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, a, 1'b1, d, sw_cur);
  endtask

  initial begin
    logic [31:0] a;
    cpu_rst = 1'b0; bif.Bus_addr = 32'h0; bif.Bus_wen = 1'b0; bif.Bus_wdata = 32'h0;
    sw = 24'h0; sw_cur = 24'h0; dram_rdata = 32'h0;
    model_reset();

    repeat (3) cyc(1'b0, A_TMR, 1'b0, 32'h0, 24'h0);
    repeat (8) rd(A_TMR);

    wr(A_LED, 32'hFF12_3456);
    repeat (3) rd(A_LED);

    wr(A_DIG, 32'h89AB_CDEF);
    repeat (40) rd(A_DIG);

    sw_cur = 24'hAB_CDEF;
    repeat (3) rd(A_SW);
    wr(A_SW, 32'h1234_5678);
    rd(A_SW);

    wr(A_TMR, 32'hFFFF_FFFE);
    repeat (3) rd(A_TMR);
    wr(A_TMR, 32'h0000_0100);
    rd(A_TMR);

    cyc(1'b1, 32'h0000_0010, 1'b1, 32'hCAFE_F00D, sw_cur);
    rd(32'h0000_0010);
    wr(A_BAD, 32'hDEAD_BEEF);
    rd(A_BAD);
    rd(A_LED);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0: a = A_DIG;
        1: a = A_LED;
        2: a = A_SW;
        3: a = A_TMR;
        4: a = 32'hFFFF_F000 | ($urandom() & 32'h0000_0FFC);
        5: a = $urandom_range(0, 32'hFFFF_EFFF);
        default: a = A_BAD;
      endcase
      if ($urandom_range(0, 7) == 0) sw_cur = $urandom();
      cyc(1'b1, a, $urandom_range(0, 1) == 1, $urandom(), sw_cur);
    end

    wr(A_LED, 32'h00AB_CDEF);
    cyc(1'b0, A_LED, 1'b1, 32'h5555_5555, sw_cur);
    cyc(1'b0, 32'h0000_0040, 1'b1, 32'h1, sw_cur);
    cyc(1'b1, A_LED, 1'b0, 32'h0, sw_cur);
    repeat (10) rd(A_TMR);

    repeat (3) @(posedge cpu_clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_bridge.md
BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 The block SHALL take parameter SCAN_DIV, default 50000: cpu_clk cycles each 7-segment digit stays enabled.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 cpu_clk  in  1  system clock; all state updates on the rising edge.
REQ-004 cpu_rst  in  1  asynchronous active-low reset.
REQ-005 Bus_addr  in  32  byte address from the CPU memory stage.
REQ-006 Bus_wen  in  1  write strobe, full 32-bit word.
REQ-007 Bus_wdata  in  32  write data.
REQ-008 Bus_rdata  out  32  read data, combinational.
REQ-009 dram_addr  out  14  word address, equal to Bus_addr[15:2].
REQ-010 dram_wen  out  1  DRAM write enable.
REQ-011 dram_wdata  out  32  equal to Bus_wdata.
REQ-012 dram_rdata  in  32  DRAM read data, combinational.
REQ-013 sw  in  24  asynchronous switch inputs.
REQ-014 led  out  24  LED drive, active-high.
REQ-015 dig_en  out  8  digit enables, active-low, one-hot-zero.
REQ-016 seg  out  8  segments {DP,G,F,E,D,C,B,A}, active-low.

Function
REQ-017 The address map SHALL be:
- Bus_addr < 0xFFFF_F000: DRAM.
- 0xFFFF_F000: DIG (R/W).
- 0xFFFF_F060: LED (R/W).
- 0xFFFF_F070: SW (read-only).
- 0xFFFF_F080: TIMER (R/W).
- Any other address >= 0xFFFF_F000 is unmapped.
REQ-018 dram_wen SHALL equal Bus_wen only for DRAM-range addresses; it SHALL be 0 otherwise.
REQ-019 Bus_rdata SHALL select by address:
- DRAM range: dram_rdata.
- DIG, LED, TIMER: the register value.
- SW: {8'h0, sw_sync}.
- Unmapped: 32'h0.
REQ-020 A peripheral write SHALL update the addressed register on the same rising edge where Bus_wen=1, so it is visible to a read one cycle later.
- Writes to SW are ignored.
- Writes to unmapped addresses are ignored.
REQ-021 LED SHALL store Bus_wdata[23:0]; the upper bits read as 0; led = LED.
REQ-022 sw SHALL pass through a two-flop synchronizer, giving sw_sync; the SW read latency is 2 cycles from an input change.
REQ-023 TIMER SHALL increment by 1 every cycle and wrap 0xFFFF_FFFF -> 0.
REQ-024 When a TIMER write and an increment occur on the same edge, TIMER SHALL load Bus_wdata (no increment that cycle).
REQ-025 A scan counter SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-026 On each scan-counter wrap, a 3-bit digit index SHALL advance by 1, wrapping 7 -> 0.
REQ-027 dig_en SHALL equal ~(8'b1 << index).
REQ-028 seg SHALL show DIG[4*index+3:4*index] using active-low hex decoding with DP off, including:
- 0 -> C0, 1 -> F9, 2 -> A4, 3 -> B0, 4 -> 99
- 5 -> 92, 6 -> 82, 7 -> F8, 8 -> 80, 9 -> 90
- A -> 88, B -> 83, C -> C6, D -> A1, E -> 86, F -> 8E
REQ-029 A DIG write SHALL change seg within the current digit period; it SHALL NOT reset the scan counter or index.
REQ-030 dig_en and seg SHALL be registered, with the same 1-cycle latency from index/DIG to output.

Reset
REQ-031 cpu_rst=0 SHALL immediately, independent of the clock, clear:
- DIG, LED, TIMER, sw_sync flops, scan counter, digit index.
REQ-032 While in reset, outputs SHALL be:
- led=0, dig_en=8'hFE, seg=8'hC0.
- dram_wen=Bus_wen for DRAM-range addresses (combinational path unaffected).
REQ-033 Assertion mid-operation, including during a write cycle, SHALL discard the write.
REQ-034 After release, TIMER SHALL read 0 at the first edge and count from there.

Verification
REQ-035 Reset then idle: led=0, dig_en=FE, seg=C0; TIMER read N cycles after release = N-1 (±0 given REQ-034).
REQ-036 Write LED 0xFF12_3456:
- led=0x12_3456 next cycle; read LED returns 0x0012_3456.
- dram_wen stays 0 throughout.
REQ-037 SCAN_DIV=4, DIG=0x89AB_CDEF:
- dig_en walks FE, FD, FB ... 7F, FE with a 4-cycle period.
- seg follows 8E, 86, A1, C6, 83, 88, 90, 80.
REQ-038 sw 0 -> 0xABCDEF:
- SW read = 0 at +1 cycle; 0x00AB_CDEF at +2.
- Write to SW is ignored.
REQ-039 TIMER=0xFFFF_FFFE free-running reads 0xFFFF_FFFF then 0; a simultaneous write of 0x100 while incrementing reads 0x100 next cycle.
REQ-040 Bus_addr=0x0000_0010, Bus_wen=1:
- dram_addr=4, dram_wen=1.
- Bus_rdata=dram_rdata.
- Address 0xFFFF_F0F0 reads 0; a write there changes nothing.
